// File: rtl/var_delay_buffer.sv
// Multi-lane variable delay line (1..max_depth en-cycles) with valid tracking and flush on delay change.
// Optional registered output stage: define VAR_DELAY_BUFFER_OUTREG_EN.
module var_delay_buffer #(
    parameter int unsigned word_size  = 16,
    parameter int unsigned channels   = 2,
    parameter int unsigned max_depth  = 16,
    parameter int unsigned delay_bits = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [delay_bits-1:0]         delay,
    input  logic [channels*word_size-1:0] d_in,
    output logic [channels*word_size-1:0] d_out,
    output logic                          d_valid,
    output logic                          filling
);
    localparam int unsigned DW = channels * word_size;
    localparam int unsigned FW = delay_bits + 1;
`ifdef VAR_DELAY_BUFFER_OUTREG_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    typedef enum logic {FILL, RUN} state_t;

    logic [DW-1:0]         data_q [max_depth];
    logic [DW-1:0]         data_d [max_depth];
    logic [max_depth-1:0]  valid_q, valid_d;
    logic [delay_bits-1:0] cur_delay_q, cur_delay_d;
    logic [FW-1:0]         fill_cnt_q, fill_cnt_d;
    state_t                state_q, state_d;

    logic [delay_bits-1:0] eff;
    logic [FW-1:0]         fill_load;
    logic                  flush;
    logic [DW-1:0]         mux_data;
    logic                  mux_valid;

    always_comb begin
        if (delay == '0)
            eff = delay_bits'(1);
        else if (32'(delay) > max_depth)
            eff = delay_bits'(max_depth);
        else
            eff = delay;
        fill_load = FW'(eff) + FW'(EXTRA);
        flush     = (eff != cur_delay_q);
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        cur_delay_d = cur_delay_q;
        fill_cnt_d  = fill_cnt_q;
        state_d     = state_q;
        // A delay change wins over en: valid bits drop, data is left stale.
        if (flush) begin
            valid_d     = '0;
            cur_delay_d = eff;
            fill_cnt_d  = fill_load;
            state_d     = FILL;
        end else if (en) begin
            data_d[0]  = d_in;
            valid_d[0] = in_valid;
            for (int unsigned i = 1; i < max_depth; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q - FW'(1);
                if (fill_cnt_q == FW'(1))
                    state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < max_depth; i++)
                data_q[i] <= '0;
            valid_q     <= '0;
            cur_delay_q <= eff;
            fill_cnt_q  <= fill_load;
            state_q     <= FILL;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            cur_delay_q <= cur_delay_d;
            fill_cnt_q  <= fill_cnt_d;
            state_q     <= state_d;
        end
    end

    always_comb begin
        mux_data  = '0;
        mux_valid = 1'b0;
        for (int unsigned i = 0; i < max_depth; i++) begin
            if (cur_delay_q == delay_bits'(i + 1)) begin
                mux_data  = data_q[i];
                mux_valid = valid_q[i];
            end
        end
    end

`ifdef VAR_DELAY_BUFFER_OUTREG_EN
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (en) begin
            out_data_d  = mux_data;
            out_valid_d = mux_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d_out   = out_data_q;
    assign d_valid = out_valid_q;
`else
    assign d_out   = mux_data;
    assign d_valid = mux_valid;
`endif

    assign filling = (state_q == FILL);

endmodule

// File: tb/tb_var_delay_buffer.sv
// Directed bench for var_delay_buffer; expected latencies add one stage when VAR_DELAY_BUFFER_OUTREG_EN is defined.
module tb_var_delay_buffer;
    localparam int unsigned WS = 16;
    localparam int unsigned CH = 2;
    localparam int unsigned MD = 16;
    localparam int unsigned DB = 5;
`ifdef VAR_DELAY_BUFFER_OUTREG_EN
    localparam int X = 1;
`else
    localparam int X = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            en = 1'b0;
    logic            in_valid = 1'b0;
    logic [DB-1:0]   delay = '0;
    logic [CH*WS-1:0] d_in = '0;
    logic [CH*WS-1:0] d_out;
    logic            d_valid;
    logic            filling;

    int checks = 0;
    int errors = 0;

    bit          pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] l0  [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [15:0] l1  [5] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};

    var_delay_buffer #(
        .word_size (WS),
        .channels  (CH),
        .max_depth (MD),
        .delay_bits(DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .in_valid(in_valid),
        .delay   (delay),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_valid (d_valid),
        .filling (filling)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] smp(input int v);
        logic [15:0] a;
        a = 16'(v);
        return {a ^ 16'hA5A5, a};
    endfunction

    // Streams samples base+j for j in [j0, j1]; line assumed flushed/reset with fill length lat.
    task automatic run_stream(input string tag, input int base, input int j0, input int j1, input int lat);
        for (int j = j0; j <= j1; j++) begin
            en = 1'b1; in_valid = 1'b1; d_in = smp(base + j);
            tick();
            chk({tag, "_filling"}, 32'(filling), 32'(j < lat));
            chk({tag, "_valid"}, 32'(d_valid), 32'(j >= lat));
            if (j >= lat) chk({tag, "_data"}, d_out, smp(base + j - lat + 1));
        end
    endtask

    task automatic do_reset(input logic [DB-1:0] dl, input int n);
        reset = 1'b1; delay = dl; en = 1'b1; in_valid = 1'b1; d_in = 32'hCAFE_F00D;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic flush_to(input string tag, input logic [DB-1:0] dl, input int base);
        delay = dl; en = 1'b1; in_valid = 1'b1; d_in = smp(base);
        tick();
        chk({tag, "_flush_valid"}, 32'(d_valid), 32'd0);
        chk({tag, "_flush_filling"}, 32'(filling), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int L;

        // Reset then steady stream at delay 4
        do_reset(5'd4, 2);
        chk("rst_valid", 32'(d_valid), 32'd0);
        chk("rst_dout", d_out, 32'd0);
        chk("rst_filling", 32'(filling), 32'd1);
        run_stream("stream4", 0, 1, 12, 4 + X);

        // Stall mid-stream at delay 3
        do_reset(5'd3, 1);
        run_stream("stall_pre", 100, 1, 6, 3 + X);
        held = smp(100 + 6 - (3 + X) + 1);
        for (int c = 0; c < 5; c++) begin
            en = 1'b0; in_valid = 1'b1; d_in = 32'hFFFF_FFFF;
            tick();
            chk("stall_valid", 32'(d_valid), 32'd1);
            chk("stall_filling", 32'(filling), 32'd0);
            chk("stall_data", d_out, held);
        end
        run_stream("stall_post", 100, 7, 12, 3 + X);

        // Delay change 4 -> 2 drops the sample on the flush edge
        do_reset(5'd4, 1);
        run_stream("chg_pre", 200, 1, 8, 4 + X);
        flush_to("chg", 5'd2, 209);
        run_stream("chg_post", 209, 1, 6, 2 + X);

        // Clamping: 0 acts as 1, 31 acts as max_depth, 31 -> 20 is not a change
        flush_to("clamp0", 5'd0, 300);
        run_stream("clamp0", 300, 1, 4, 1 + X);
        flush_to("clamp31", 5'd31, 400);
        run_stream("clamp31", 400, 1, 20, 16 + X);
        delay = 5'd20;
        run_stream("clamp20", 400, 21, 24, 16 + X);

        // Bubbles and per-lane data at full depth
        do_reset(5'd16, 1);
        L = 16 + X;
        for (int j = 1; j <= 24; j++) begin
            en = 1'b1;
            if (j <= 5) begin
                in_valid = pat[j-1]; d_in = {l1[j-1], l0[j-1]};
            end else begin
                in_valid = 1'b0; d_in = '0;
            end
            tick();
            chk("bub_filling", 32'(filling), 32'(j < L));
            if (j >= L && j - L < 5) begin
                chk("bub_valid", 32'(d_valid), 32'(pat[j-L]));
                if (pat[j-L]) chk("bub_data", d_out, {l1[j-L], l0[j-L]});
            end else begin
                chk("bub_valid_idle", 32'(d_valid), 32'd0);
            end
        end

        // Reset with samples in flight at delay 8
        do_reset(5'd8, 1);
        for (int j = 1; j <= 5; j++) begin
            en = 1'b1; in_valid = 1'b1; d_in = smp(16'h700 + j);
            tick();
        end
        do_reset(5'd8, 1);
        chk("midrst_valid", 32'(d_valid), 32'd0);
        chk("midrst_dout", d_out, 32'd0);
        chk("midrst_filling", 32'(filling), 32'd1);
        for (int j = 1; j <= 20; j++) begin
            en = 1'b1; in_valid = 1'b0; d_in = '0;
            tick();
            chk("midrst_none", 32'(d_valid), 32'd0);
            chk("midrst_fill", 32'(filling), 32'(j < 8 + X));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/var_delay_buffer.md
Name: var_delay_buffer

Overview:
- Multi-channel delay line with a runtime-selectable delay and a per-sample valid flag.
- The delay is set in en-qualified cycles, from 1 to max_depth.
- Used between FFT butterfly stages to align twiddle/data paths whose latency differs per FFT size or mode.
- Supports pipeline stall (en) and flushes cleanly when the delay changes.

Parameters:
- word_size, 16, bits per channel sample
- channels, 2, number of parallel lanes (e.g. re/im); all lanes share one valid bit
- max_depth, 16, maximum delay in stages (>= 1)
- delay_bits, 5, width of the delay port; must satisfy 2^delay_bits > max_depth

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  advance enable; 0 = stall (all state frozen except the delay-change flush)
- in_valid  input  1  d_in carries a valid sample
- delay  input  delay_bits  requested delay in en-cycles
- d_in  input  channels*word_size  packed samples; lane k at [k*word_size +: word_size]
- d_out  output  channels*word_size  delayed samples, same packing
- d_valid  output  1  d_out carries a valid sample
- filling  output  1  high while the line refills after reset or a delay change

Behaviour:
- Storage: max_depth stages, each holding {valid, channels*word_size data}. Stage 0 is the input side.
- Delay clamping: eff = delay clamped to 1..max_depth (0 maps to 1; values above max_depth map to max_depth). cur_delay register holds the active eff.
- Normal edge, en=1:
  - stage[0] <= {in_valid, d_in}
  - stage[i] <= stage[i-1] for i = 1..max_depth-1
- Normal edge, en=0: all stages hold.
- Output: {d_valid, d_out} = stage[cur_delay-1], combinational mux from registers.
  - A sample presented on an en=1 edge appears at the output after exactly cur_delay en=1 edges.
  - en=0 cycles do not count toward the delay.
- Data registers are never cleared except by reset. Invalid slots may hold stale data; the bench must check d_out only when d_valid=1.
- Delay change detect: eff != cur_delay on an edge, regardless of en. That edge is a flush edge:
  - cur_delay <= eff
  - all stage valid bits <= 0; data bits hold
  - the incoming sample is discarded even if en=1 and in_valid=1
  - fill_cnt <= eff
- Fill state machine, two states:
  - FILL: filling=1. Decrement fill_cnt on each en=1 edge. Move to RUN on the edge where fill_cnt goes 1 -> 0.
  - RUN: filling=0. Move back to FILL only on a flush edge or reset.
- During FILL, d_valid is naturally 0 because the valid bits were cleared. No extra gating is applied.
- A flush edge during FILL reloads fill_cnt with the new eff and stays in FILL.
- Reset (takes priority over everything):
  - all stage valid and data bits <= 0
  - cur_delay <= clamp(delay), fill_cnt <= clamp(delay), state <= FILL
  - after reset: d_out=0, d_valid=0, filling=1
- Reset mid-operation discards all in-flight samples. There are no output glitches beyond the reset values.
- No backpressure: the consumer must accept d_out whenever d_valid=1 and en=1.

Optional Feature:
- Macro: VAR_DELAY_BUFFER_OUTREG_EN
- Defined:
  - d_out/d_valid are registered: on en=1 edges out_reg <= stage[cur_delay-1], held when en=0.
  - Total latency is cur_delay+1 en-edges.
  - On a flush edge or reset, the out_reg valid bit <= 0 (and out_reg data <= 0 on reset).
  - fill_cnt loads eff+1.
- Undefined: the combinational-mux output as described in Behaviour. No extra stage.

Test Plan:
- Reset then steady stream: reset 2 cycles with delay=4, en=1, in_valid=1, d_in = 1, 2, 3, ... -> filling=1 for 4 edges; first d_valid=1 with lane0=1 on the 4th edge after reset release; then one sample per cycle in order.
- Stall: delay=3 streaming; hold en=0 for 5 cycles mid-stream -> d_out/d_valid/filling frozen; order resumes with no loss or duplication; latency stays 3 en-edges.
- Delay change: running at delay=4 with valid data; switch to delay=2 -> next edge d_valid=0 and the input sample is dropped; filling=1 for 2 en-edges; new samples then emerge after 2 edges.
- Clamping: delay=0 -> behaves as 1 (lane0 of sample N appears on the next edge); delay=31 with max_depth=16 -> latency 16; changing 31 -> 20 causes no flush (both clamp to 16).
- Bubbles and channels: channels=2, delay=max_depth=16, in_valid pattern 1,0,1,1,0 with distinct lane values -> same valid pattern and exact per-lane data after 16 edges.
- Reset mid-stream and macro variant: assert reset with delay=8 and 5 samples in flight -> d_valid=0, d_out=0, filling=1 the next cycle; none of the 5 samples ever appear. With VAR_DELAY_BUFFER_OUTREG_EN the same stream has latency 9.
